// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dmem_pkg;

  typedef enum logic {ST_CLEAR, ST_RUN} dmem_state_e;

  // Upper bounds for the helper functions; callers zero-extend into these widths.
  localparam int MAX_NB     = 32;
  localparam int MAX_DATA_W = MAX_NB * 8;

  // A legal mask is one naturally aligned, power-of-two sized run of lanes.
  function automatic logic mask_legal(input logic [MAX_NB-1:0] mask, input int nb);
    logic              ok;
    logic [MAX_NB-1:0] pat;
    ok = 1'b0;
    for (int sz = 1; sz <= MAX_NB; sz = sz * 2) begin
      for (int off = 0; off < MAX_NB; off = off + sz) begin
        pat = ((MAX_NB'(1) << sz) - MAX_NB'(1)) << off;
        if ((sz <= nb) && (off + sz <= nb) && (mask == pat)) ok = 1'b1;
      end
    end
    return ok;
  endfunction

  // Enabled lanes take the new byte, disabled lanes keep the stored byte.
  function automatic logic [MAX_DATA_W-1:0] lane_merge(input logic [MAX_DATA_W-1:0] old_w,
                                                       input logic [MAX_DATA_W-1:0] new_w,
                                                       input logic [MAX_NB-1:0]     mask);
    logic [MAX_DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_NB; i++) begin
      if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_rsp_pipe.sv
// Response register chain carrying valid/err/data from the accept edge to the port.
// Latency: LAT register stages; the first stage captures on the accept edge.
// Backpressure: none; every entry advances each cycle and the consumer must sink it.
module dmem_rsp_pipe #(
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_vld,
  input  logic              i_err,
  input  logic [DATA_W-1:0] i_dat,
  output logic              o_vld,
  output logic              o_err,
  output logic [DATA_W-1:0] o_dat
);

  logic [LAT-1:0]    vld_q, vld_d;
  logic [LAT-1:0]    err_q, err_d;
  logic [DATA_W-1:0] dat_q [LAT];
  logic [DATA_W-1:0] dat_d [LAT];

  // Shift every stage forward by one, loading stage 0 from the input.
  always_comb begin
    vld_d    = vld_q;
    err_d    = err_q;
    dat_d    = dat_q;
    vld_d[0] = i_vld;
    err_d[0] = i_err;
    dat_d[0] = i_dat;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      err_d[i] = err_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  // Reset flushes anything in flight so no stale response escapes.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      for (int i = 0; i < LAT; i++) dat_q[i] <= dat_d[i];
    end
  end

  assign o_vld = vld_q[LAT-1];
  assign o_err = err_q[LAT-1];
  assign o_dat = dat_q[LAT-1];

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory: byte-merge stores, range/mask checks, optional post-reset clear (DMEM_CLEAR_EN).
// Latency: response RD_LAT cycles after the accept edge; one request per cycle, in order.
// Backpressure: ready is low only during the clear sweep; responses cannot be stalled.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16384,
  parameter int RD_LAT = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_wren,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_bmask,
  output logic                o_rsp_valid,
  output logic [DATA_W-1:0]   o_rdata,
  output logic                o_rsp_err,
  output logic                o_busy
);

  localparam int NB    = DATA_W / 8;
  localparam int LG_NB = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  // One extra bit so DEPTH == 2^ADDR_W (byte-wide memories) still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0]     word_idx;
  logic [IDX_W-1:0]      idx;
  logic                  in_range;
  logic                  mask_ok;
  logic                  acc;
  logic                  st_ok;
  logic [MAX_NB-1:0]     mask_full;
  logic [MAX_DATA_W-1:0] old_full, new_full, merged_full;
  logic                  unused_merge;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_dat;

  logic              rsp_err_in;
  logic [DATA_W-1:0] rsp_dat_in;

  dmem_state_e state_q, state_d;
  logic        ready_q, ready_d;
`ifdef DMEM_CLEAR_EN
  logic             busy_q, busy_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
`endif

  // Request decode: word index, range/mask legality and the merged store word.
  always_comb begin
    word_idx  = i_addr >> LG_NB;
    idx       = word_idx[IDX_W-1:0];
    in_range  = {1'b0, word_idx} < DEPTH_A;
    mask_full = '0;
    mask_full[NB-1:0] = i_bmask;
    mask_ok   = mask_legal(mask_full, NB);
    acc       = i_req_valid & ready_q;
    st_ok     = acc & i_wren & in_range & mask_ok;
    old_full  = '0;
    old_full[DATA_W-1:0] = mem_q[idx];
    new_full  = '0;
    new_full[DATA_W-1:0] = i_wdata;
    merged_full = lane_merge(old_full, new_full, mask_full);
  end

  assign unused_merge = ^merged_full;

  // Single write port shared by the clear sweep and legal stores.
  always_comb begin
    wr_en  = st_ok;
    wr_idx = idx;
    wr_dat = merged_full[DATA_W-1:0];
`ifdef DMEM_CLEAR_EN
    if (state_q == ST_CLEAR) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q;
      wr_dat = '0;
    end
`endif
  end

  // Array storage; contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_dat;
  end

  // Response payload: loads return the word read on the accept edge, everything else 0.
  always_comb begin
    rsp_err_in = acc & (~in_range | (i_wren & ~mask_ok));
    rsp_dat_in = '0;
    if (acc && !i_wren && in_range) rsp_dat_in = mem_q[idx];
  end

  // FSM next state; ready/busy are computed from the next state so they register in step with it.
  always_comb begin
    state_d = state_q;
`ifdef DMEM_CLEAR_EN
    ptr_d = ptr_q;
    if (state_q == ST_CLEAR) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
    end
    busy_d = (state_d == ST_CLEAR);
`endif
    ready_d = (state_d == ST_RUN);
  end

  // FSM state and registered handshake outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
`ifdef DMEM_CLEAR_EN
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
`else
      state_q <= ST_RUN;
`endif
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
`ifdef DMEM_CLEAR_EN
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
`endif
      ready_q <= ready_d;
    end
  end

  assign o_req_ready = ready_q;
`ifdef DMEM_CLEAR_EN
  assign o_busy = busy_q;
`else
  assign o_busy = 1'b0;
`endif

  dmem_rsp_pipe #(
    .DATA_W (DATA_W),
    .LAT    (RD_LAT)
  ) u_rsp_pipe (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_vld   (acc),
    .i_err   (rsp_err_in),
    .i_dat   (rsp_dat_in),
    .o_vld   (o_rsp_valid),
    .o_err   (o_rsp_err),
    .o_dat   (o_rdata)
  );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (RD_LAT 1 and 2) share one request stream.
// Expected responses are queued with their due cycle and compared on the falling edge.
module tb_dmem_ctrl;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_req_valid = 1'b0;
  logic [15:0] i_addr = '0;
  logic        i_wren = 1'b0;
  logic [31:0] i_wdata = '0;
  logic [3:0]  i_bmask = '0;

  logic [1:0]  rdy, rvld, rerr, busy;
  logic [31:0] rdata [2];

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] dat;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [3:0]  m;
    logic        eerr;
    logic [31:0] edat;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  vec_t tab[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;

  dmem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(1)) u_dut1 (
    .i_clk(clk), .i_reset(rst_n), .i_req_valid(i_req_valid), .o_req_ready(rdy[0]),
    .i_addr(i_addr), .i_wren(i_wren), .i_wdata(i_wdata), .i_bmask(i_bmask),
    .o_rsp_valid(rvld[0]), .o_rdata(rdata[0]), .o_rsp_err(rerr[0]), .o_busy(busy[0]));

  dmem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(2)) u_dut2 (
    .i_clk(clk), .i_reset(rst_n), .i_req_valid(i_req_valid), .o_req_ready(rdy[1]),
    .i_addr(i_addr), .i_wren(i_wren), .i_wdata(i_wdata), .i_bmask(i_bmask),
    .o_rsp_valid(rvld[1]), .o_rdata(rdata[1]), .o_rsp_err(rerr[1]), .o_busy(busy[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_rsp(input int d);
    exp_t e;
    logic have;
    have = 1'b0;
    if (d == 0 && q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); have = 1'b1; end
    if (d == 1 && q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1'b1; end
    if (have) begin
      check($sformatf("lat%0d_rsp_valid", d + 1), 32'(rvld[d]), 32'd1);
      check($sformatf("lat%0d_rsp_err", d + 1), 32'(rerr[d]), 32'(e.err));
      check($sformatf("lat%0d_rdata", d + 1), rdata[d], e.dat);
    end else begin
      check($sformatf("lat%0d_idle_valid", d + 1), 32'(rvld[d]), 32'd0);
    end
  endtask

  // Scoreboard: every falling edge, each instance either owes a response or must be idle.
  always @(negedge clk) begin
    chk_rsp(0);
    chk_rsp(1);
  end

  task automatic push(input logic err, input logic [31:0] dat);
    q0.push_back('{cyc + 1, err, dat});
    q1.push_back('{cyc + 2, err, dat});
  endtask

  // Called at a falling edge; the request is accepted on the following rising edge.
  task automatic req(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                     input logic [3:0] m, input logic eerr, input logic [31:0] edat);
    i_req_valid = 1'b1;
    i_wren      = wr;
    i_addr      = a;
    i_wdata     = wd;
    i_bmask     = m;
    push(eerr, edat);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    i_req_valid = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    check("rst_ready", 32'(rdy), 32'd0);
    check("rst_rsp_valid", 32'(rvld), 32'd0);
    check("rst_rsp_err", 32'(rerr), 32'd0);
    check("rst_rdata", rdata[0] | rdata[1], 32'd0);
`ifdef DMEM_CLEAR_EN
    check("rst_busy", 32'(busy), 32'd3);
`else
    check("rst_busy", 32'(busy), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called right after reset release (a falling edge); returns at a falling edge.
  task automatic wait_ready();
`ifdef DMEM_CLEAR_EN
    int n;
    int n_busy;
    n = 0;
    n_busy = 0;
    // Requests offered during the sweep must be ignored (no response queued).
    i_req_valid = 1'b1;
    i_wren      = 1'b0;
    i_addr      = 16'h0000;
    repeat (64) begin
      @(posedge clk);
      #1;
      n++;
      if (rdy === 2'b11) break;
      if (busy === 2'b11 && rdy === 2'b00) n_busy++;
    end
    i_req_valid = 1'b0;
    check("clear_cycles_to_ready", 32'(n), 32'(DEPTH));
    check("clear_busy_cycles", 32'(n_busy), 32'(DEPTH - 1));
    check("run_busy", 32'(busy), 32'd0);
`else
    @(posedge clk);
    #1;
    check("ready_first_edge", 32'(rdy), 32'd3);
    check("run_busy", 32'(busy), 32'd0);
`endif
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    i_req_valid = 1'b0;
    n = 0;
    while ((q0.size() + q1.size()) > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("drain_pending", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  initial begin
    // Vectors are applied back-to-back, so latency and throughput are checked throughout.
    tab.push_back('{1'b1, 16'h0000, 32'h0BADF00D, 4'hF, 1'b0, 32'h0});
    tab.push_back('{1'b1, 16'h0010, 32'hAABBCCDD, 4'hF, 1'b0, 32'h0});
    tab.push_back('{1'b1, 16'h0010, 32'h00000011, 4'h1, 1'b0, 32'h0});
    tab.push_back('{1'b1, 16'h0010, 32'h22220000, 4'hC, 1'b0, 32'h0});
    tab.push_back('{1'b0, 16'h0010, 32'h0,        4'h0, 1'b0, 32'h2222CC11});
    tab.push_back('{1'b1, 16'h0010, 32'hFFFFFFFF, 4'h5, 1'b1, 32'h0});
    tab.push_back('{1'b1, 16'h0010, 32'hFFFFFFFF, 4'h0, 1'b1, 32'h0});
    tab.push_back('{1'b1, 16'h0010, 32'hFFFFFFFF, 4'h6, 1'b1, 32'h0});
    tab.push_back('{1'b1, 16'h0010, 32'hFFFFFFFF, 4'h7, 1'b1, 32'h0});
    tab.push_back('{1'b1, 16'h0010, 32'hFFFFFFFF, 4'hE, 1'b1, 32'h0});
    tab.push_back('{1'b0, 16'h0010, 32'h0,        4'h0, 1'b0, 32'h2222CC11});
    tab.push_back('{1'b0, 16'h0040, 32'h0,        4'h0, 1'b1, 32'h0});
    tab.push_back('{1'b1, 16'h0040, 32'h12345678, 4'hF, 1'b1, 32'h0});
    tab.push_back('{1'b0, 16'h0000, 32'h0,        4'h0, 1'b0, 32'h0BADF00D});
    tab.push_back('{1'b1, 16'h0014, 32'h00000000, 4'hF, 1'b0, 32'h0});
    tab.push_back('{1'b1, 16'h0014, 32'h0000AB00, 4'h2, 1'b0, 32'h0});
    tab.push_back('{1'b1, 16'h0014, 32'hCD000000, 4'h8, 1'b0, 32'h0});
    tab.push_back('{1'b1, 16'h0014, 32'h00EF0000, 4'h4, 1'b0, 32'h0});
    tab.push_back('{1'b0, 16'h0014, 32'h0,        4'h5, 1'b0, 32'hCDEFAB00});
    tab.push_back('{1'b1, 16'h0008, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0});
    tab.push_back('{1'b0, 16'h0008, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF});
    tab.push_back('{1'b1, 16'h003C, 32'h99AABBCC, 4'hF, 1'b0, 32'h0});
    tab.push_back('{1'b1, 16'h003C, 32'h55667788, 4'h3, 1'b0, 32'h0});
    tab.push_back('{1'b0, 16'h003E, 32'h0,        4'h0, 1'b0, 32'h99AA7788});
    tab.push_back('{1'b0, 16'h0000, 32'h0,        4'h0, 1'b0, 32'h0BADF00D});
    tab.push_back('{1'b0, 16'h0008, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF});
    tab.push_back('{1'b0, 16'h0010, 32'h0,        4'h0, 1'b0, 32'h2222CC11});
    tab.push_back('{1'b0, 16'h0014, 32'h0,        4'h0, 1'b0, 32'hCDEFAB00});
    tab.push_back('{1'b0, 16'hFFFC, 32'h0,        4'h0, 1'b1, 32'h0});

    do_reset();
    wait_ready();

`ifdef DMEM_CLEAR_EN
    // The sweep must have zeroed the first and last words.
    req(1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 32'h0);
    req(1'b0, 16'h003C, 32'h0, 4'h0, 1'b0, 32'h0);
`endif

    foreach (tab[i]) req(tab[i].wr, tab[i].addr, tab[i].wd, tab[i].m, tab[i].eerr, tab[i].edat);
    drain();

    // A load in flight at reset: the 1-cycle instance has answered, the 2-cycle one must not.
    @(negedge clk);
    i_req_valid = 1'b1;
    i_wren      = 1'b0;
    i_addr      = 16'h0008;
    q0.push_back('{cyc + 1, 1'b0, 32'hDEADBEEF});
    @(negedge clk);
    i_req_valid = 1'b0;
    #1;
    do_reset();

`ifdef DMEM_CLEAR_EN
    // Reset again part-way through the sweep; it must restart from the beginning.
    repeat (7) @(posedge clk);
    #1;
    check("midclear_busy", 32'(busy), 32'd3);
    do_reset();
`endif
    wait_ready();

    // Store then load right after a reset.
    req(1'b1, 16'h0004, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0);
    req(1'b0, 16'h0004, 32'h0,        4'h0, 1'b0, 32'hCAFEF00D);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
